// File: rtl/plane_pwm_dbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : plane_pwm_dbuf_ctrl
// Brief    : OUT_NUM-channel PWM driver with a double-buffered brightness
//            memory loaded over a strobed MCU bus; bank swap on period wrap.
//            Optional macro PWM_PHASE_SPREAD_EN staggers per-channel phase.
// Revision : 1.0 - initial release
// ============================================================================
module plane_pwm_dbuf_ctrl #(
  parameter int OUT_NUM      = 64,
  parameter int D_WIDTH      = 8,
  parameter int C_WIDTH      = 4,
  parameter int MCU_DIV_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] dataIn,
  input  logic               dataEn,
  input  logic               rs,
  output logic [OUT_NUM-1:0] pwmOut,
  output logic               mcuClk,
  output logic               frameSync,
  output logic               swapPending,
  output logic               cmdErr
);

  localparam int IDX_W = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int A_W   = D_WIDTH - 1;

  localparam logic [C_WIDTH-1:0] c_cntMax  = '1;
  localparam logic [IDX_W-1:0]   c_addrMax = IDX_W'(OUT_NUM - 1);

  localparam logic [D_WIDTH-1:0] c_opClear    = D_WIDTH'(8'h01);
  localparam logic [D_WIDTH-1:0] c_opAddrZero = D_WIDTH'(8'h02);
  localparam logic [D_WIDTH-1:0] c_opInc      = D_WIDTH'(8'h04);
  localparam logic [D_WIDTH-1:0] c_opDec      = D_WIDTH'(8'h05);
  localparam logic [D_WIDTH-1:0] c_opSwap     = D_WIDTH'(8'h08);
  localparam logic [D_WIDTH-1:0] c_opPwmOff   = D_WIDTH'(8'h10);
  localparam logic [D_WIDTH-1:0] c_opPwmOn    = D_WIDTH'(8'h11);

  // ---------------------------------------------------------------- bus sync
  logic [1:0]         r_enSync;
  logic [1:0]         r_rsSync;
  logic [D_WIDTH-1:0] r_dataSync0;
  logic [D_WIDTH-1:0] r_dataSync1;
  logic               r_enPrev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enSync    <= '0;
      r_rsSync    <= '0;
      r_dataSync0 <= '0;
      r_dataSync1 <= '0;
      r_enPrev    <= 1'b0;
    end else begin
      r_enSync    <= {r_enSync[0], dataEn};
      r_rsSync    <= {r_rsSync[0], rs};
      r_dataSync0 <= dataIn;
      r_dataSync1 <= r_dataSync0;
      r_enPrev    <= r_enSync[1];
    end
  end

  logic w_strobe;
  logic w_cmd;
  logic w_wr;
  assign w_strobe = r_enPrev & ~r_enSync[1];
  assign w_cmd    = w_strobe & r_rsSync[1];
  assign w_wr     = w_strobe & ~r_rsSync[1];

  // ---------------------------------------------------------------- decode
  logic [A_W-1:0] w_addrField;
  logic           w_clear;
  logic           w_addrZero;
  logic           w_setInc;
  logic           w_setDec;
  logic           w_reqSwap;
  logic           w_pwmOff;
  logic           w_pwmOn;
  logic           w_setAddr;
  logic           w_err;

  assign w_addrField = r_dataSync1[A_W-1:0];

  always_comb begin
    w_clear    = 1'b0;
    w_addrZero = 1'b0;
    w_setInc   = 1'b0;
    w_setDec   = 1'b0;
    w_reqSwap  = 1'b0;
    w_pwmOff   = 1'b0;
    w_pwmOn    = 1'b0;
    w_setAddr  = 1'b0;
    w_err      = 1'b0;
    if (w_cmd) begin
      if (r_dataSync1[D_WIDTH-1]) begin
        if (int'(w_addrField) < OUT_NUM) w_setAddr = 1'b1;
        else                             w_err     = 1'b1;
      end else begin
        case (r_dataSync1)
          c_opClear:    w_clear    = 1'b1;
          c_opAddrZero: w_addrZero = 1'b1;
          c_opInc:      w_setInc   = 1'b1;
          c_opDec:      w_setDec   = 1'b1;
          c_opSwap:     w_reqSwap  = 1'b1;
          c_opPwmOff:   w_pwmOff   = 1'b1;
          c_opPwmOn:    w_pwmOn    = 1'b1;
          default:      w_err      = 1'b1;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- control
  logic [IDX_W-1:0]        r_addr;
  logic [IDX_W-1:0]        w_addrStep;
  logic                    r_incDec;
  logic                    r_pwmEn;
  logic                    r_frontSel;
  logic                    r_swapPending;
  logic                    r_cmdErr;
  logic [C_WIDTH-1:0]      r_cnt;
  logic [MCU_DIV_LOG2-1:0] r_div;
  logic                    w_wrap;
  logic                    w_doSwap;

  assign w_wrap   = (r_cnt == c_cntMax);
  assign w_doSwap = w_wrap & r_swapPending;

  always_comb begin
    if (r_incDec) w_addrStep = (r_addr == c_addrMax) ? '0 : r_addr + 1'b1;
    else          w_addrStep = (r_addr == '0) ? c_addrMax : r_addr - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr        <= '0;
      r_incDec      <= 1'b0;
      r_pwmEn       <= 1'b0;
      r_frontSel    <= 1'b0;
      r_swapPending <= 1'b0;
      r_cmdErr      <= 1'b0;
      r_cnt         <= '0;
      r_div         <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_div <= r_div + 1'b1;

      if (w_setAddr)       r_addr <= w_addrField[IDX_W-1:0];
      else if (w_addrZero) r_addr <= '0;
      else if (w_wr)       r_addr <= w_addrStep;

      if (w_setInc)      r_incDec <= 1'b1;
      else if (w_setDec) r_incDec <= 1'b0;

      if (w_pwmOn)       r_pwmEn <= 1'b1;
      else if (w_pwmOff) r_pwmEn <= 1'b0;

      // A request in the wrap cycle only arms the swap for the following wrap.
      if (w_doSwap) begin
        r_frontSel    <= ~r_frontSel;
        r_swapPending <= 1'b0;
      end else if (w_reqSwap) begin
        r_swapPending <= 1'b1;
      end

      if (w_err) r_cmdErr <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- banks
  // Writes use the registered frontSel, so a write in the swap cycle still
  // targets the bank that is about to become the front.
  logic [C_WIDTH-1:0] r_bank0 [OUT_NUM];
  logic [C_WIDTH-1:0] r_bank1 [OUT_NUM];
  logic [C_WIDTH-1:0] w_wrVal;

  assign w_wrVal = r_dataSync1[C_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_NUM; i++) r_bank0[i] <= '0;
    end else if (r_frontSel) begin
      if (w_clear) begin
        for (int i = 0; i < OUT_NUM; i++) r_bank0[i] <= '0;
      end else if (w_wr) begin
        r_bank0[r_addr] <= w_wrVal;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_NUM; i++) r_bank1[i] <= '0;
    end else if (!r_frontSel) begin
      if (w_clear) begin
        for (int i = 0; i < OUT_NUM; i++) r_bank1[i] <= '0;
      end else if (w_wr) begin
        r_bank1[r_addr] <= w_wrVal;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [OUT_NUM-1:0] w_pwmNext;

  for (genvar i = 0; i < OUT_NUM; i++) begin : g_ch
    logic [C_WIDTH-1:0] w_front;
    logic [C_WIDTH-1:0] w_phase;
    assign w_front = r_frontSel ? r_bank1[i] : r_bank0[i];
`ifdef PWM_PHASE_SPREAD_EN
    assign w_phase = r_cnt - C_WIDTH'(i);
`else
    assign w_phase = r_cnt;
`endif
    assign w_pwmNext[i] = r_pwmEn & (w_phase < w_front);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwmOut <= '0;
    else        pwmOut <= w_pwmNext;
  end

  assign mcuClk      = r_div[MCU_DIV_LOG2-1];
  assign frameSync   = w_wrap;
  assign swapPending = r_swapPending;
  assign cmdErr      = r_cmdErr;

endmodule
`default_nettype wire
